// File: rtl/line_tap_reader_if.sv
// rtl/line_tap_reader_if.sv - line buffer tap inputs, read request and 3x3 window outputs
interface line_tap_reader_if #(
  parameter int DW = 10
);
  logic            VGA_VS;
  logic            LINE_START;
  logic [DW-1:0]   taps0x;
  logic [DW-1:0]   taps1x;
  logic [DW-1:0]   PIX_IN;
  logic            READ_Request;
  logic [12:0]     READ_Cont;
  logic [3*DW-1:0] WIN_TOP;
  logic [3*DW-1:0] WIN_MID;
  logic [3*DW-1:0] WIN_BOT;
  logic            WIN_VALID;
  logic [11:0]     WIN_X;
  logic [11:0]     WIN_Y;

  modport slave (
    input  VGA_VS, LINE_START, taps0x, taps1x, PIX_IN,
    output READ_Request, READ_Cont, WIN_TOP, WIN_MID, WIN_BOT, WIN_VALID, WIN_X, WIN_Y
  );

  modport master (
    output VGA_VS, LINE_START, taps0x, taps1x, PIX_IN,
    input  READ_Request, READ_Cont, WIN_TOP, WIN_MID, WIN_BOT, WIN_VALID, WIN_X, WIN_Y
  );
endinterface

// File: rtl/line_tap_reader.sv
// rtl/line_tap_reader.sv - reads one buffered line per LINE_START and assembles a sliding 3x3 window
module line_tap_reader #(
  parameter int H_ACTIVE = 640,
  parameter int DW       = 10
) (
  input  logic               VGA_CLK,
  input  logic               RST,
  line_tap_reader_if.slave   bus
);

  localparam int            AW        = 13;
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE - 1);
  localparam logic [11:0]   CNT_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [11:0]     line_cnt;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            pipe_valid;
  logic [AW-1:0]   pipe_addr;
  logic            line_run;
  logic [11:0]     line_y;

  logic [3*DW-1:0] row_top;
  logic [3*DW-1:0] row_mid;
  logic [3*DW-1:0] row_bot;
  logic            win_valid;
  logic [11:0]     win_x;
  logic [11:0]     win_y;

  logic            flush;
  logic            accept;
  logic            last_read;
  logic            emit;

  // A frame blank behaves like a reset of the line pipeline.
  assign flush     = RST | ~bus.VGA_VS;
  // The pipeline must drain before a new line clears the row registers.
  assign accept    = bus.LINE_START & (state != IDLE) & ~rd_req & ~pipe_valid;
  assign last_read = rd_req & (rd_addr == LAST_ADDR);
  assign emit      = pipe_valid & line_run & (state == RUN) & (pipe_addr >= AW'(2));

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!bus.VGA_VS) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = PRIME;
        PRIME:   if (line_cnt >= 12'd2) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (flush || state == IDLE) begin
      line_cnt <= '0;
    end else if (last_read && line_cnt != CNT_MAX) begin
      line_cnt <= line_cnt + 12'd1;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (flush) begin
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      line_run <= 1'b0;
      line_y   <= '0;
    end else if (accept) begin
      rd_req   <= 1'b1;
      rd_addr  <= '0;
      line_run <= (state == RUN);
      line_y   <= line_cnt - 12'd1;
    end else if (rd_req) begin
      if (last_read) begin
        rd_req  <= 1'b0;
        rd_addr <= '0;
      end else begin
        rd_addr <= rd_addr + AW'(1);
      end
    end
  end

  // Tracks the one-cycle RAM latency: data on the taps belongs to pipe_addr.
  always_ff @(posedge VGA_CLK) begin
    if (flush) begin
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
    end else begin
      pipe_valid <= rd_req;
      pipe_addr  <= rd_addr;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (flush || accept) begin
      row_top   <= '0;
      row_mid   <= '0;
      row_bot   <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (pipe_valid) begin
      row_top   <= {row_top[2*DW-1:0], bus.taps0x};
      row_mid   <= {row_mid[2*DW-1:0], bus.taps1x};
      row_bot   <= {row_bot[2*DW-1:0], bus.PIX_IN};
      win_valid <= emit;
      if (emit) begin
        win_x <= 12'(pipe_addr - AW'(1));
        win_y <= line_y;
      end
    end else begin
      win_valid <= 1'b0;
    end
  end

  assign bus.READ_Request = rd_req;
  assign bus.READ_Cont    = rd_addr;
  assign bus.WIN_TOP      = row_top;
  assign bus.WIN_MID      = row_mid;
  assign bus.WIN_BOT      = row_bot;
  assign bus.WIN_VALID    = win_valid;
  assign bus.WIN_X        = win_x;
  assign bus.WIN_Y        = win_y;

endmodule

// File: doc/line_tap_reader.md
LINE_TAP_READER -- requirements
Module: line_tap_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line read from the three-line buffer.
REQ-002 SHALL have parameter DW, default 10, pixel width.
REQ-003 SHALL have port VGA_CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port VGA_VS  input  1  vertical sync, active-low; low = frame blanking.
REQ-006 SHALL have port LINE_START  input  1  one-cycle pulse requesting a read of one buffered line.
REQ-007 SHALL have port taps0x  input  DW  oldest buffered line (window top row).
REQ-008 SHALL have port taps1x  input  DW  middle buffered line (window middle row).
REQ-009 SHALL have port PIX_IN  input  DW  current line pixel, same address/latency as taps (window bottom row).
REQ-010 SHALL have port READ_Request  output  1  read enable to the line buffer.
REQ-011 SHALL have port READ_Cont  output  13  line buffer read address.
REQ-012 SHALL have ports WIN_TOP, WIN_MID, WIN_BOT  output  3*DW each  window rows; [DW-1:0] = rightmost (newest) column.
REQ-013 SHALL have port WIN_VALID  output  1  window contents are a complete 3x3 neighbourhood.
REQ-014 SHALL have ports WIN_X, WIN_Y  output  12 each  centre pixel coordinate of current window.

Function
REQ-015 SHALL implement frame FSM IDLE, PRIME, RUN.
REQ-016 IDLE -> PRIME when VGA_VS high; any state -> IDLE on the cycle after VGA_VS sampled low.
REQ-017 SHALL count completed line reads (line_cnt, 12 bits, saturating at 4095), cleared in IDLE.
REQ-018 PRIME -> RUN when line_cnt reaches 2 (two lines buffered); no WIN_VALID in PRIME or IDLE.
REQ-019 LINE_START sampled high at cycle t (state PRIME/RUN, not busy) -> READ_Request high cycles t+1..t+H_ACTIVE.
REQ-020 READ_Cont = k at cycle t+1+k, k = 0..H_ACTIVE-1; READ_Cont = 0 whenever READ_Request low.
REQ-021 LINE_START while READ_Request high SHALL be ignored; LINE_START in IDLE SHALL be ignored.
REQ-022 Read data for address k arrives at t+2+k (one-cycle RAM latency); shifted into all three row registers, visible at t+3+k.
REQ-023 Row shift: new pixel enters [DW-1:0], older columns move up; registers cleared at every LINE_START acceptance.
REQ-024 WIN_VALID at t+3+k iff state RUN and k >= 2; WIN_X = k-1, WIN_Y = line_cnt-1 (captured at LINE_START).
REQ-025 Exactly H_ACTIVE-2 WIN_VALID cycles per RUN line; no border replication.
REQ-026 line_cnt increments on the cycle READ_Request falls.
REQ-027 VGA_VS low mid-line SHALL abort: READ_Request and WIN_VALID low next cycle, pipeline flushed.

Reset
REQ-028 RST high SHALL at next edge force: state IDLE, line_cnt 0, READ_Request 0, READ_Cont 0, all WIN_* 0, WIN_VALID 0.
REQ-029 RST mid-line SHALL abort identically to REQ-027; no partial window emitted after reset.

Verification
REQ-030 Reset then VS high, LINE_START x2 (H_ACTIVE=8) -> 8-cycle READ_Request each, READ_Cont 0..7, zero WIN_VALID.
REQ-031 Third LINE_START at t, taps0x=10+k, taps1x=20+k, PIX_IN=30+k -> WIN_VALID t+5..t+10; at t+5 WIN_TOP={10,11,12}, WIN_MID={20,21,22}, WIN_BOT={30,31,32}, WIN_X=1, WIN_Y=1.
REQ-032 LINE_START re-pulsed at t+3 during busy read -> ignored; READ_Request still exactly 8 cycles.
REQ-033 VGA_VS low at t+4 of a RUN line -> READ_Request, WIN_VALID 0 from t+5; next frame needs 2 PRIME lines again.
REQ-034 RST at t+4 of a RUN line -> all outputs 0 at t+5, state IDLE.
REQ-035 255 back-to-back lines, H_ACTIVE=640 -> each RUN line 638 WIN_VALID, WIN_X 1..638, WIN_Y increments by 1.
